mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-ported simulated memory between the core's instruction-fetch port (read-only) and its load/store port (read/write, byte mask). It sits between the RV32I core and `simulated_mem`. Every memory command is launched from registers, and each transaction is a request/done handshake. Contending requesters are served round-robin. The block also handles misaligned fetches and read timeouts.

## Interface
- `TIMEOUT`, default 15: maximum cycles spent in ACCESS waiting for `mem_valid` on a read before the transaction faults.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held high with `i_addr` stable until `i_done`.
- `i_addr`  in  32  fetch byte address.
- `i_done`  out  1  one-cycle completion pulse for the fetch port.
- `i_rdata`  out  32  fetched word; valid while `i_done`=1, 0 otherwise.
- `i_fault`  out  1  valid with `i_done`; 1 = misaligned address or timeout.
- `d_req`  in  1  data request; held with fields stable until `d_done`.
- `d_cmd`  in  1  `MEM_CMD_READ` / `MEM_CMD_WRITE` (from `defines.vh`).
- `d_addr`  in  32  data byte address.
- `d_mask`  in  4  byte-lane write enables.
- `d_wdata`  in  32  write data.
- `d_done`  out  1  one-cycle completion pulse for the data port.
- `d_rdata`  out  32  load word; valid while `d_done`=1 for reads, 0 otherwise.
- `d_fault`  out  1  valid with `d_done`; 1 = read timeout.
- `mem_addr`, `mem_mask`, `mem_cmd`, `mem_write_data`  out  32/4/1/32  registered memory command.
- `mem_enable`  out  1  registered; high only in ACCESS.
- `mem_load_data`  in  32  memory read data.
- `mem_valid`  in  1  memory read-data valid.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE, arbitration:**
  - A single requester wins.
  - If both request, the winner is the port not granted last (`last_grant`).
  - `last_grant` updates on every grant. Reset value is DATA, so the first conflict goes to fetch.
- **IDLE, on grant:**
  - Latch the owner.
  - Load `mem_addr`/`mem_mask`/`mem_cmd`/`mem_write_data` from the winner. Fetch uses mask 4'b1111 and cmd READ; data uses its own fields.
  - Go to ACCESS with `mem_enable`=1.
- **Misaligned fetch:** a fetch grant with `i_addr[1:0]`≠0 skips ACCESS. It goes directly to RESP with `i_fault`=1 and no memory enable.
- **ACCESS, read:**
  - When `mem_valid`=1, capture `mem_load_data` into the owner's rdata register and go to RESP.
  - A cycle counter (width ≥ clog2(TIMEOUT+1)) counts cycles in ACCESS. On reaching TIMEOUT without `mem_valid`, go to RESP with fault=1 and rdata=0.
- **ACCESS, write:** always exactly one cycle, then go to RESP. `mem_valid` is ignored.
- **Leaving ACCESS:** `mem_enable`, `mem_addr`, `mem_mask`, `mem_cmd` and `mem_write_data` all return to 0.
- **RESP:**
  - The owner's done=1 for exactly one cycle, with rdata/fault.
  - The non-owner's done stays 0 and its rdata stays 0.
  - Next state is IDLE unconditionally.
- **Re-arbitration:** a requester still asserting req in IDLE after its done is treated as a new request.
- **Reset** (async, any state):
  - State → IDLE; `last_grant` → DATA.
  - All outputs → 0 immediately, including `mem_enable`. No partial write may be issued after reset asserts.

## Timing
- Read or write, no contention, memory valid immediately:
  - req sampled at edge 0;
  - `mem_enable` high during cycle 1;
  - done high during cycle 2;
  - IDLE at cycle 3.
- Peak throughput: one transaction per 3 cycles.
- Misaligned fetch: done+fault high in cycle 1; `mem_enable` never asserts.
- Read timeout: `mem_enable` high for exactly TIMEOUT cycles, then done+fault in the following cycle.
- Memory writes combinationally while enabled, so `mem_*` must be registered and glitch-free. `mem_enable` is high for exactly one cycle per write.
- A request arriving while `busy`=1 waits; it is not dropped.
- Simultaneous requests in IDLE: the loser is granted in the IDLE cycle right after the winner's RESP, provided it is still requesting.

## Test plan
- **Single fetch:** `i_req` with `i_addr`=0x100 and memory word 0x00500093 → `mem_enable` in cycle 1 with `mem_addr`=0x100, mask=F, cmd=READ; `i_done`=1 with `i_rdata`=0x00500093 and `i_fault`=0 in cycle 2.
- **Byte store then load:** write 0x000000AB with mask 4'b0001 to 0x200, which holds 0x11223344 → a single one-cycle enable. A following read of 0x200 returns 0x112233AB.
- **Contention:** `i_req` and `d_req` asserted together from reset and held → grant order fetch, data, fetch, data. Each done arrives 3 cycles apart; no two dones are ever high in the same cycle.
- **Misaligned fetch:** `i_addr`=0x102 → `i_done`=1 and `i_fault`=1 in cycle 1; `mem_enable` stays 0 throughout.
- **Timeout:** stub memory holds `mem_valid`=0 and a data read is issued with TIMEOUT=15 → `mem_enable` high for 15 cycles, then `d_done`=1, `d_fault`=1, `d_rdata`=0.
- **Reset mid-ACCESS:** `rst_n` pulled low during a write's ACCESS cycle → `mem_enable` drops to 0 asynchronously. After release: `busy`=0, all dones 0, and the next conflict grants fetch first.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch and load/store ports.
// Memory commands are driven only from registers, so the memory never sees a combinational glitch.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_done,
   output logic [31:0] i_rdata,
   output logic        i_fault,
   input  logic        d_req,
   input  logic        d_cmd,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_mask,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        d_fault,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_mask,
   output logic        mem_cmd,
   output logic [31:0] mem_write_data,
   output logic        mem_enable,
   input  logic [31:0] mem_load_data,
   input  logic        mem_valid,
   output logic        busy
);
   localparam logic MEM_CMD_READ  = 1'b0;
   localparam logic MEM_CMD_WRITE = 1'b1;
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;
   localparam int   CW    = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

   state_e        state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_q, last_d;
   logic          en_q, en_d;
   logic [31:0]   addr_q, addr_d;
   logic [3:0]    mask_q, mask_d;
   logic          cmd_q, cmd_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          fault_q, fault_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          gnt;
   logic          leave;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         owner_q <= OWN_I;
         last_q  <= OWN_D;
         en_q    <= 1'b0;
         addr_q  <= '0;
         mask_q  <= '0;
         cmd_q   <= MEM_CMD_READ;
         wdata_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         en_q    <= en_d;
         addr_q  <= addr_d;
         mask_q  <= mask_d;
         cmd_q   <= cmd_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      en_d    = en_q;
      addr_d  = addr_q;
      mask_d  = mask_q;
      cmd_d   = cmd_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      cnt_d   = cnt_q;
      leave   = 1'b0;
      // On contention the port that did not win last time gets the grant.
      gnt     = (i_req && d_req) ? ~last_q : d_req;
      case (state_q)
         S_IDLE: begin
            if (i_req || d_req) begin
               owner_d = gnt;
               last_d  = gnt;
               rdata_d = '0;
               fault_d = 1'b0;
               cnt_d   = '0;
               if (gnt == OWN_I && i_addr[1:0] != 2'b00) begin
                  state_d = S_RESP;
                  fault_d = 1'b1;
               end else if (gnt == OWN_I) begin
                  state_d = S_ACCESS;
                  en_d    = 1'b1;
                  addr_d  = i_addr;
                  mask_d  = 4'hF;
                  cmd_d   = MEM_CMD_READ;
                  wdata_d = '0;
               end else begin
                  state_d = S_ACCESS;
                  en_d    = 1'b1;
                  addr_d  = d_addr;
                  mask_d  = d_mask;
                  cmd_d   = d_cmd;
                  wdata_d = d_wdata;
               end
            end
         end
         S_ACCESS: begin
            if (cmd_q == MEM_CMD_WRITE) begin
               leave = 1'b1;
            end else if (mem_valid) begin
               leave   = 1'b1;
               rdata_d = mem_load_data;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               leave   = 1'b1;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            if (leave) begin
               state_d = S_RESP;
               en_d    = 1'b0;
               addr_d  = '0;
               mask_d  = '0;
               cmd_d   = MEM_CMD_READ;
               wdata_d = '0;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign i_done         = (state_q == S_RESP) && (owner_q == OWN_I);
   assign d_done         = (state_q == S_RESP) && (owner_q == OWN_D);
   assign i_rdata        = i_done ? rdata_q : 32'h0;
   assign d_rdata        = d_done ? rdata_q : 32'h0;
   assign i_fault        = i_done & fault_q;
   assign d_fault        = d_done & fault_q;
   assign mem_addr       = addr_q;
   assign mem_mask       = mask_q;
   assign mem_cmd        = cmd_q;
   assign mem_write_data = wdata_q;
   assign mem_enable     = en_q;
   assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts grant order,
// completion cycles, read data and fault flags from a reference copy of memory.
module tb_mem_arbiter;
   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req, i_done, i_fault;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_cmd, d_done, d_fault;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_mask;
   logic [31:0] mem_addr, mem_write_data, mem_load_data;
   logic [3:0]  mem_mask;
   logic        mem_cmd, mem_enable, mem_valid, busy;
   logic        stall;

   logic [31:0] mem_arr [256];
   logic [31:0] ref_mem [256];
   bit          ref_last;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_fault(i_fault),
      .d_req(d_req), .d_cmd(d_cmd), .d_addr(d_addr), .d_mask(d_mask), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .d_fault(d_fault),
      .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_cmd(mem_cmd),
      .mem_write_data(mem_write_data), .mem_enable(mem_enable),
      .mem_load_data(mem_load_data), .mem_valid(mem_valid), .busy(busy)
   );

   assign mem_valid     = mem_enable && (mem_cmd == 1'b0) && !stall;
   assign mem_load_data = mem_enable ? mem_arr[mem_addr[9:2]] : 32'h0;

   always @(posedge clk) begin
      if (mem_enable && mem_cmd) begin
         for (int b = 0; b < 4; b++)
            if (mem_mask[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One request pair; expected cycles and data come from the arbitration rules.
   task automatic run_txn(input bit do_i, input logic [31:0] ia,
                          input bit do_d, input bit dcmd, input logic [31:0] da,
                          input logic [3:0] dm, input logic [31:0] dw,
                          output logic [31:0] irs, output logic [31:0] drs);
      bit first_d, i_mis, seen_i, seen_d, act_d;
      int t_i, t_d, lat_i, n_en, exp_en;
      i_mis   = do_i && (ia[1:0] != 2'b00);
      lat_i   = i_mis ? 1 : 2;
      first_d = (do_i && do_d) ? !ref_last : do_d;
      if (do_i && do_d) begin
         if (first_d) begin t_d = 2; t_i = 3 + lat_i; ref_last = 1'b0; end
         else         begin t_i = lat_i; t_d = lat_i + 3; ref_last = 1'b1; end
      end else begin
         t_i = lat_i; t_d = 2;
         if (do_i || do_d) ref_last = do_d;
      end
      exp_en = ((do_i && !i_mis) ? 1 : 0) + (do_d ? 1 : 0);
      @(negedge clk);
      i_req = do_i; i_addr = ia;
      d_req = do_d; d_cmd = dcmd; d_addr = da; d_mask = dm; d_wdata = dw;
      seen_i = !do_i; seen_d = !do_d; n_en = 0; irs = '0; drs = '0;
      for (int k = 1; k <= 12 && !(seen_i && seen_d); k++) begin
         @(negedge clk);
         chk("dual_done", {31'b0, i_done & d_done}, 32'h0);
         if (mem_enable) begin
            n_en++;
            act_d = (do_i && do_d) ? (first_d ? !seen_d : seen_i) : do_d;
            if (act_d) begin
               chk("maddr_d", mem_addr, da);
               chk("mmask_d", {28'b0, mem_mask}, {28'b0, dm});
               chk("mcmd_d", {31'b0, mem_cmd}, {31'b0, dcmd});
               if (dcmd) chk("mwdata_d", mem_write_data, dw);
            end else begin
               chk("maddr_i", mem_addr, ia);
               chk("mmask_i", {28'b0, mem_mask}, 32'hF);
               chk("mcmd_i", {31'b0, mem_cmd}, 32'h0);
            end
         end
         if (i_done) begin
            if (seen_i) chk("i_done_extra", 32'h1, 32'h0);
            else begin
               seen_i = 1'b1;
               chk("i_lat", k, t_i);
               chk("i_fault", {31'b0, i_fault}, {31'b0, i_mis});
               chk("i_rdata", i_rdata, i_mis ? 32'h0 : ref_mem[ia[9:2]]);
               irs = i_rdata;
               i_req = 1'b0;
            end
         end
         if (d_done) begin
            if (seen_d) chk("d_done_extra", 32'h1, 32'h0);
            else begin
               seen_d = 1'b1;
               chk("d_lat", k, t_d);
               chk("d_fault", {31'b0, d_fault}, 32'h0);
               chk("d_rdata", d_rdata, dcmd ? 32'h0 : ref_mem[da[9:2]]);
               drs = d_rdata;
               if (dcmd)
                  for (int b = 0; b < 4; b++)
                     if (dm[b]) ref_mem[da[9:2]][8*b +: 8] = dw[8*b +: 8];
               d_req = 1'b0;
            end
         end
      end
      if (!seen_i) chk("i_done_timeout", 32'h0, 32'h1);
      if (!seen_d) chk("d_done_timeout", 32'h0, 32'h1);
      chk("n_enable", n_en, exp_en);
   endtask

   initial begin
      logic [31:0] ir, dr, old, ia, da;
      bit ok, di, dd;
      int n_en;
      i_req = 0; i_addr = 0; d_req = 0; d_cmd = 0; d_addr = 0; d_mask = 0; d_wdata = 0;
      stall = 0;
      for (int w = 0; w < 256; w++) begin
         mem_arr[w] = $urandom;
         ref_mem[w] = mem_arr[w];
      end
      mem_arr[32'h100 >> 2] = 32'h00500093; ref_mem[32'h100 >> 2] = 32'h00500093;
      mem_arr[32'h200 >> 2] = 32'h11223344; ref_mem[32'h200 >> 2] = 32'h11223344;
      ref_last = 1'b1;
      #23;
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_en", {31'b0, mem_enable}, 32'h0);
      chk("rst_dones", {30'b0, i_done, d_done}, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      // Both held from reset: fetch, data, fetch, data, three cycles apart.
      @(negedge clk);
      i_req = 1; i_addr = 32'h100; d_req = 1; d_cmd = 0; d_addr = 32'h204; d_mask = 4'hF;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk("hold_i_done", {31'b0, i_done}, {31'b0, (k == 2 || k == 8)});
         chk("hold_d_done", {31'b0, d_done}, {31'b0, (k == 5 || k == 11)});
         if (k == 2) chk("hold_i_rdata", i_rdata, 32'h00500093);
      end
      i_req = 0; d_req = 0;

      run_txn(1, 32'h100, 0, 0, 0, 0, 0, ir, dr);
      chk("fetch_word", ir, 32'h00500093);
      run_txn(1, 32'h102, 0, 0, 0, 0, 0, ir, dr);
      run_txn(0, 0, 1, 1, 32'h200, 4'b0001, 32'h000000AB, ir, dr);
      run_txn(0, 0, 1, 0, 32'h200, 4'hF, 0, ir, dr);
      chk("byte_load", dr, 32'h112233AB);

      // Read timeout with a memory that never answers.
      stall = 1; n_en = 0; ok = 0;
      @(negedge clk);
      d_req = 1; d_cmd = 0; d_addr = 32'h40; d_mask = 4'hF;
      for (int k = 1; k <= 40 && !ok; k++) begin
         @(negedge clk);
         if (mem_enable) n_en++;
         if (d_done) begin
            ok = 1;
            chk("to_lat", k, TO + 1);
            chk("to_fault", {31'b0, d_fault}, 32'h1);
            chk("to_rdata", d_rdata, 32'h0);
            d_req = 0;
         end
      end
      if (!ok) chk("to_done_timeout", 32'h0, 32'h1);
      chk("to_n_enable", n_en, TO);
      d_req = 0; stall = 0; ref_last = 1'b1;

      // Reset during a write's ACCESS cycle.
      old = mem_arr[32'h300 >> 2];
      @(negedge clk);
      d_req = 1; d_cmd = 1; d_addr = 32'h300; d_mask = 4'hF; d_wdata = 32'hDEADBEEF;
      @(posedge clk); #2;
      chk("mid_en_pre", {31'b0, mem_enable}, 32'h1);
      rst_n = 1'b0; #1;
      chk("mid_en_async", {31'b0, mem_enable}, 32'h0);
      chk("mid_busy", {31'b0, busy}, 32'h0);
      chk("mid_maddr", mem_addr, 32'h0);
      d_req = 0;
      @(negedge clk); rst_n = 1'b1;
      chk("mid_dones", {30'b0, i_done, d_done}, 32'h0);
      chk("mid_nowrite", mem_arr[32'h300 >> 2], old);
      ref_last = 1'b1;
      run_txn(1, 32'h300, 1, 0, 32'h304, 4'hF, 0, ir, dr);

      for (int n = 0; n < 150; n++) begin
         di = $urandom_range(0, 1);
         dd = di ? 1'($urandom_range(0, 1)) : 1'b1;
         ia = $urandom & 32'h3FC;
         if ($urandom_range(0, 3) == 0) ia[1:0] = 2'($urandom_range(1, 3));
         da = $urandom & 32'h3FC;
         run_txn(di, ia, dd, 1'($urandom_range(0, 1)), da, 4'($urandom), $urandom, ir, dr);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
